mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 EX_to_MEM_valid  in  1  upstream instruction valid.
REQ-005 EX_to_MEM_bus  in  74  [73] res_from_mem, [72] load_sign, [71:70] load_size (00 byte, 01 half, 10 word, 11 reserved→word), [69] gr_we, [68:64] dest, [63:32] alu_result (load address for loads), [31:0] pc.
REQ-006 MEM_allow  out  1  stage can accept a new instruction this cycle.
REQ-007 MEM_to_WB_valid  out  1  instruction offered to WB.
REQ-008 MEM_to_WB_bus  out  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
REQ-009 WB_allow  in  1  WB accepts this cycle.
REQ-010 data_sram_rdata  in  32  load data, meaningful only when data_sram_rdata_valid=1.
REQ-011 data_sram_rdata_valid  in  1  one-cycle pulse per load.
REQ-012 MEM_dest_bus  out  5  forwarding destination, 0 if none.
REQ-013 MEM_value_bus  out  32  forwarding value (final_result).
REQ-014 MEM_load_pending  out  1  valid load whose data has not yet arrived; ID stalls on match.

Function
REQ-015 Registers: MEM_valid, bus_r[73:0], data state, rdata_buf[31:0].
REQ-016 MEM_go = ~res_from_mem | data_have; data_have = (state==HAVE) | (state==WAIT & data_sram_rdata_valid).
REQ-017 MEM_allow = ~MEM_valid | (MEM_go & WB_allow).
REQ-018 If MEM_allow: MEM_valid <= EX_to_MEM_valid; bus_r <= EX_to_MEM_bus only if EX_to_MEM_valid=1.
REQ-019 MEM_to_WB_valid = MEM_valid & MEM_go; purely combinational, zero added latency beyond the bus_r register.
REQ-020 Transfer to WB occurs on cycles with MEM_to_WB_valid & WB_allow; bus stable while MEM_to_WB_valid=1 and WB_allow=0.
REQ-021 Data FSM states IDLE, WAIT, HAVE.
REQ-022 Any state: load accepted (MEM_allow & EX_to_MEM_valid & EX res_from_mem) -> WAIT; non-load accepted or stage empties -> IDLE.
REQ-023 WAIT & rdata_valid & ~WB_allow -> HAVE, rdata_buf <= data_sram_rdata.
REQ-024 WAIT & ~rdata_valid -> stay WAIT.
REQ-025 HAVE: hold until WB_allow, then per REQ-022.
REQ-026 rdata_valid in IDLE or HAVE ignored; no state or data change.
REQ-027 Load source word = rdata_buf in HAVE, else data_sram_rdata (same-cycle bypass).
REQ-028 Byte: select word[8*a+7:8*a], a = alu_result[1:0]; half: word[15:0] if alu_result[1]=0 else word[31:16]; alu_result[0] ignored for half.
REQ-029 Extension: load_sign=1 sign-extends, 0 zero-extends to 32 bits; word unaffected.
REQ-030 final_result = extracted load data if res_from_mem, else alu_result.
REQ-031 MEM_dest_bus = (MEM_valid & gr_we) ? dest : 0.
REQ-032 MEM_value_bus = final_result; MEM_load_pending = MEM_valid & res_from_mem & ~data_have.
REQ-033 Simultaneous leave and accept in one cycle permitted (back-to-back throughput 1/cycle for non-loads and for loads with same-cycle data).

Reset
REQ-034 Asynchronous reset forces MEM_valid=0, state=IDLE, bus_r=0, rdata_buf=0 immediately.
REQ-035 Outputs during reset: MEM_allow=1, MEM_to_WB_valid=0, MEM_to_WB_bus=0, MEM_dest_bus=0, MEM_load_pending=0.
REQ-036 Reset mid-load discards the instruction; a late rdata_valid after reset release is ignored (IDLE).

Verification
REQ-037 Non-load add, gr_we=1, dest=5, alu_result=0x1234, WB_allow=1 -> next cycle MEM_to_WB_valid=1, bus={1,5,0x00001234,pc}, MEM_dest_bus=5.
REQ-038 ld.b signed, addr low bits 2, rdata 0x12_80_34_56 same cycle -> final_result=0xFFFFFF80; ld.hu addr[1]=1 -> 0x00001280.
REQ-039 Load, rdata_valid delayed 3 cycles -> MEM_load_pending=1, MEM_allow=0, MEM_to_WB_valid=0 for 3 cycles, then result issued.
REQ-040 Load, rdata 0xDEADBEEF (ld.w) arrives while WB_allow=0 for 2 cycles -> HAVE, bus holds 0xDEADBEEF, stray rdata_valid=0x0 in HAVE ignored.
REQ-041 Reset asserted in WAIT -> outputs zero asynchronously; post-reset rdata_valid pulse produces no MEM_to_WB_valid.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Holds one instruction from EX, waits for
// load data when needed, extracts/extends loaded bytes/halves and offers the
// final result to WB with a valid/allow handshake. Also drives the forwarding
// and load-pending signals that ID uses to decide bypass or stall.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  // EX -> MEM
  input  logic        EX_to_MEM_valid,
  input  logic [73:0] EX_to_MEM_bus,
  output logic        MEM_allow,
  // MEM -> WB
  output logic        MEM_to_WB_valid,
  output logic [69:0] MEM_to_WB_bus,
  input  logic        WB_allow,
  // data SRAM response
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_rdata_valid,
  // forwarding / hazard info to ID
  output logic [4:0]  MEM_dest_bus,
  output logic [31:0] MEM_value_bus,
  output logic        MEM_load_pending
);

  // IDLE: no load data expected; WAIT: load issued, data not yet seen;
  // HAVE: data arrived while WB was stalled and is parked in r_rdata_buf.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HAVE = 2'd2
  } state_t;

  logic        r_mem_valid;
  logic [73:0] r_bus;
  state_t      r_state;
  logic [31:0] r_rdata_buf;

  state_t      w_state_nxt;
  logic        w_data_have;
  logic        w_buf_load;
  logic        w_mem_go;
  logic        w_allow;
  logic        w_accept;

  // Fields of the held instruction
  logic        w_res_from_mem;
  logic        w_load_sign;
  logic [1:0]  w_load_size;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;

  // Load data path
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;

  assign w_res_from_mem = r_bus[73];
  assign w_load_sign    = r_bus[72];
  assign w_load_size    = r_bus[71:70];
  assign w_gr_we        = r_bus[69];
  assign w_dest         = r_bus[68:64];
  assign w_alu_result   = r_bus[63:32];
  assign w_pc           = r_bus[31:0];

  // Handshake: a load may only leave once its data is in hand (buffered or
  // arriving this very cycle); a non-load leaves whenever WB accepts.
  assign w_mem_go = ~w_res_from_mem | w_data_have;
  assign w_allow  = ~r_mem_valid | (w_mem_go & WB_allow);
  assign w_accept = w_allow & EX_to_MEM_valid;

  assign MEM_allow       = w_allow;
  assign MEM_to_WB_valid = r_mem_valid & w_mem_go;

  // Stage occupancy; also loads the instruction bus when a new one enters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_bus       <= 74'd0;
    end else if (w_allow) begin
      r_mem_valid <= EX_to_MEM_valid;
      if (EX_to_MEM_valid)
        r_bus <= EX_to_MEM_bus;
    end
  end

  // Data FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Data FSM: next state. Any turnover of the stage restarts the FSM based
  // on what enters; otherwise only WAIT reacts, parking data when WB stalls.
  // A stray rdata_valid in IDLE or HAVE therefore changes nothing.
  always_comb begin
    w_state_nxt = r_state;
    if (w_allow) begin
      if (EX_to_MEM_valid & EX_to_MEM_bus[73])
        w_state_nxt = S_WAIT;
      else
        w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_WAIT: if (data_sram_rdata_valid & ~WB_allow) w_state_nxt = S_HAVE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Data FSM: outputs. data_have covers both parked data and same-cycle
  // arrival; buf_load captures arriving data only when it cannot leave now.
  always_comb begin
    w_data_have = 1'b0;
    w_buf_load  = 1'b0;
    case (r_state)
      S_HAVE: w_data_have = 1'b1;
      S_WAIT: begin
        w_data_have = data_sram_rdata_valid;
        w_buf_load  = data_sram_rdata_valid & ~WB_allow;
      end
      default: begin
        w_data_have = 1'b0;
        w_buf_load  = 1'b0;
      end
    endcase
  end

  // Parking buffer for load data that arrived while WB was stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rdata_buf <= 32'd0;
    else if (w_buf_load & ~w_allow)
      r_rdata_buf <= data_sram_rdata;
  end

  // Load extraction: pick source word, then byte/half lane by address,
  // then sign- or zero-extend. Size 11 is treated as a word.
  always_comb begin
    w_word = (r_state == S_HAVE) ? r_rdata_buf : data_sram_rdata;
    case (w_alu_result[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_alu_result[1] ? w_word[31:16] : w_word[15:0];
    case (w_load_size)
      2'b00:   w_load_data = {{24{w_load_sign & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{w_load_sign & w_half[15]}}, w_half};
      default: w_load_data = w_word;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

  assign MEM_to_WB_bus    = {w_gr_we, w_dest, w_final_result, w_pc};
  assign MEM_dest_bus     = (r_mem_valid & w_gr_we) ? w_dest : 5'd0;
  assign MEM_value_bus    = w_final_result;
  assign MEM_load_pending = r_mem_valid & w_res_from_mem & ~w_data_have;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset outputs, non-load pass-through,
// byte/half extraction with same-cycle data, delayed data, WB stall with
// parked data, and reset in the middle of a load.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        EX_to_MEM_valid;
  logic [73:0] EX_to_MEM_bus;
  logic        MEM_allow;
  logic        MEM_to_WB_valid;
  logic [69:0] MEM_to_WB_bus;
  logic        WB_allow;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rdata_valid;
  logic [4:0]  MEM_dest_bus;
  logic [31:0] MEM_value_bus;
  logic        MEM_load_pending;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .EX_to_MEM_valid       (EX_to_MEM_valid),
    .EX_to_MEM_bus         (EX_to_MEM_bus),
    .MEM_allow             (MEM_allow),
    .MEM_to_WB_valid       (MEM_to_WB_valid),
    .MEM_to_WB_bus         (MEM_to_WB_bus),
    .WB_allow              (WB_allow),
    .data_sram_rdata       (data_sram_rdata),
    .data_sram_rdata_valid (data_sram_rdata_valid),
    .MEM_dest_bus          (MEM_dest_bus),
    .MEM_value_bus         (MEM_value_bus),
    .MEM_load_pending      (MEM_load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic res, input logic sgn, input logic [1:0] sz,
                                     input logic we, input logic [4:0] dst,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {res, sgn, sz, we, dst, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    EX_to_MEM_valid = 1'b0;
    EX_to_MEM_bus = '0;
    WB_allow = 1'b1;
    data_sram_rdata = '0;
    data_sram_rdata_valid = 1'b0;

    // ---- reset state
    #2;
    chk("rst_allow",   74'(MEM_allow), 74'd1);
    chk("rst_wbvalid", 74'(MEM_to_WB_valid), 74'd0);
    chk("rst_wbbus",   74'(MEM_to_WB_bus), 74'd0);
    chk("rst_dest",    74'(MEM_dest_bus), 74'd0);
    chk("rst_pend",    74'(MEM_load_pending), 74'd0);
    tick;
    reset = 1'b0;

    // ---- non-load add r5 = 0x1234
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b0, 1'b0, 2'b10, 1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000);
    #1 chk("add_allow_in", 74'(MEM_allow), 74'd1);
    tick;
    EX_to_MEM_valid = 1'b0;
    #1;
    chk("add_wbvalid", 74'(MEM_to_WB_valid), 74'd1);
    chk("add_wbbus",   74'(MEM_to_WB_bus), 74'({1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000}));
    chk("add_dest",    74'(MEM_dest_bus), 74'd5);
    chk("add_pend",    74'(MEM_load_pending), 74'd0);
    tick;
    chk("add_gone",    74'(MEM_to_WB_valid), 74'd0);
    chk("add_dest0",   74'(MEM_dest_bus), 74'd0);

    // ---- ld.b signed at ...2, then ld.hu at ...2 back-to-back
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b1, 1'b1, 2'b00, 1'b1, 5'd7, 32'h0000_1002, 32'h1C00_0010);
    tick;
    EX_to_MEM_valid = 1'b0;
    #1;
    chk("ldb_pend",    74'(MEM_load_pending), 74'd1);
    chk("ldb_noallow", 74'(MEM_allow), 74'd0);
    chk("ldb_novalid", 74'(MEM_to_WB_valid), 74'd0);
    data_sram_rdata_valid = 1'b1;
    data_sram_rdata = 32'h1280_3456;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b1, 1'b0, 2'b01, 1'b1, 5'd8, 32'h0000_1002, 32'h1C00_0014);
    #1;
    chk("ldb_valid",   74'(MEM_to_WB_valid), 74'd1);
    chk("ldb_value",   74'(MEM_value_bus), 74'h0000_0000_FFFF_FF80);
    chk("ldb_allow",   74'(MEM_allow), 74'd1);
    chk("ldb_pend0",   74'(MEM_load_pending), 74'd0);
    tick;
    EX_to_MEM_valid = 1'b0;
    #1;
    chk("ldhu_valid",  74'(MEM_to_WB_valid), 74'd1);
    chk("ldhu_wbbus",  74'(MEM_to_WB_bus), 74'({1'b1, 5'd8, 32'h0000_1280, 32'h1C00_0014}));
    tick;
    data_sram_rdata_valid = 1'b0;
    #1 chk("ldhu_gone", 74'(MEM_to_WB_valid), 74'd0);

    // ---- ld.h signed at ...0 and ld.bu at ...3, same-cycle data
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b1, 1'b1, 2'b01, 1'b1, 5'd10, 32'h0000_2000, 32'h1C00_0020);
    tick;
    EX_to_MEM_bus = mk(1'b1, 1'b0, 2'b00, 1'b1, 5'd11, 32'h0000_2003, 32'h1C00_0024);
    data_sram_rdata_valid = 1'b1;
    data_sram_rdata = 32'hA500_8001;
    #1 chk("ldh_value", 74'(MEM_value_bus), 74'h0000_0000_FFFF_8001);
    tick;
    EX_to_MEM_valid = 1'b0;
    #1 chk("ldbu_value", 74'(MEM_value_bus), 74'h0000_0000_0000_00A5);
    tick;
    data_sram_rdata_valid = 1'b0;

    // ---- ld.w with data 3 cycles late
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b1, 1'b0, 2'b10, 1'b1, 5'd9, 32'h0000_3000, 32'h1C00_0030);
    tick;
    EX_to_MEM_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_pend",    74'(MEM_load_pending), 74'd1);
      chk("late_noallow", 74'(MEM_allow), 74'd0);
      chk("late_novalid", 74'(MEM_to_WB_valid), 74'd0);
      tick;
    end
    data_sram_rdata_valid = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("late_valid", 74'(MEM_to_WB_valid), 74'd1);
    chk("late_value", 74'(MEM_value_bus), 74'h0000_0000_CAFE_F00D);
    chk("late_dest",  74'(MEM_dest_bus), 74'd9);
    tick;
    data_sram_rdata_valid = 1'b0;

    // ---- ld.w data arrives while WB stalls -> parked in HAVE
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b1, 1'b0, 2'b10, 1'b1, 5'd3, 32'h0000_4000, 32'h1C00_0040);
    tick;
    EX_to_MEM_valid = 1'b0;
    WB_allow = 1'b0;
    data_sram_rdata_valid = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall_valid",   74'(MEM_to_WB_valid), 74'd1);
    chk("stall_noallow", 74'(MEM_allow), 74'd0);
    tick;
    // stray pulse in HAVE, plus an EX instruction that must not enter
    data_sram_rdata = 32'h0000_0000;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b0, 1'b0, 2'b10, 1'b1, 5'd1, 32'h5555_5555, 32'h1C00_0050);
    #1;
    chk("have_wbbus", 74'(MEM_to_WB_bus), 74'({1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1C00_0040}));
    chk("have_pend",  74'(MEM_load_pending), 74'd0);
    tick;
    data_sram_rdata_valid = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    #1 chk("have_hold", 74'(MEM_value_bus), 74'h0000_0000_DEAD_BEEF);
    WB_allow = 1'b1;
    #1 chk("have_allow", 74'(MEM_allow), 74'd1);
    tick;
    EX_to_MEM_valid = 1'b0;
    #1 chk("next_in", 74'(MEM_to_WB_bus), 74'({1'b1, 5'd1, 32'h5555_5555, 32'h1C00_0050}));
    tick;

    // ---- reset while waiting for load data
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_bus = mk(1'b1, 1'b0, 2'b10, 1'b1, 5'd12, 32'h0000_6000, 32'h1C00_0060);
    tick;
    EX_to_MEM_valid = 1'b0;
    #1 chk("rw_pend", 74'(MEM_load_pending), 74'd1);
    reset = 1'b1;
    #1;
    chk("rw_allow", 74'(MEM_allow), 74'd1);
    chk("rw_pend0", 74'(MEM_load_pending), 74'd0);
    chk("rw_bus",   74'(MEM_to_WB_bus), 74'd0);
    chk("rw_dest",  74'(MEM_dest_bus), 74'd0);
    tick;
    reset = 1'b0;
    data_sram_rdata_valid = 1'b1;
    data_sram_rdata = 32'h7777_7777;
    #1 chk("post_novalid", 74'(MEM_to_WB_valid), 74'd0);
    tick;
    data_sram_rdata_valid = 1'b0;
    #1 chk("post_novalid2", 74'(MEM_to_WB_valid), 74'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
